// File: rtl/b1_trk_corr_bank.sv
// BOC tracking correlator bank: per-tap sign-wiped coherent integration over a
// programmable number of PRN periods, dumped scaled and saturated over valid/ready.
module b1_trk_corr_bank #(
   parameter int unsigned NUM_TAPS = 3,
   parameter int unsigned IN_W     = 16,
   parameter int unsigned ACC_W    = 33,
   parameter int unsigned OUT_W    = 24,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                      rx_clk,
   input  logic                      rx_rst,
   input  logic [IN_W-1:0]           rx_src_real,
   input  logic [IN_W-1:0]           rx_src_imag,
   input  logic [NUM_TAPS-1:0]       rx_loc_boc,
   input  logic                      rx_prn_sop,
   input  logic [CNT_W-1:0]          cfg_int_len,
   input  logic [5:0]                cfg_shift,
   output logic                      tx_dump_valid,
   input  logic                      tx_dump_ready,
   output logic [NUM_TAPS*OUT_W-1:0] tx_dump_real,
   output logic [NUM_TAPS*OUT_W-1:0] tx_dump_imag,
   output logic                      tx_dump_sat,
   output logic                      tx_dump_ovf,
   output logic [15:0]               tx_dump_cnt
);

   localparam logic [0:0] WAIT_SOP = 1'b0;
   localparam logic [0:0] INTEG    = 1'b1;

   logic [0:0]                 stateQ;
   logic                       sopAl;
   logic [CNT_W-1:0]           periodCnt;
   logic [CNT_W-1:0]           intLen;
   logic [CNT_W-1:0]           lenEff;
   logic                       dumpNow;
   logic signed [IN_W:0]       xRe;
   logic signed [IN_W:0]       xIm;
   logic signed [IN_W:0]       sRe    [NUM_TAPS];
   logic signed [IN_W:0]       sIm    [NUM_TAPS];
   logic signed [ACC_W-1:0]    sExtRe [NUM_TAPS];
   logic signed [ACC_W-1:0]    sExtIm [NUM_TAPS];
   logic signed [ACC_W-1:0]    accRe  [NUM_TAPS];
   logic signed [ACC_W-1:0]    accIm  [NUM_TAPS];
   logic [NUM_TAPS*OUT_W-1:0]  dumpReal;
   logic [NUM_TAPS*OUT_W-1:0]  dumpImag;
   logic [2*NUM_TAPS-1:0]      satVec;

   // Returns {clipFlag, value}: shift, then clip to the signed OUT_W range.
   function automatic logic [OUT_W:0] scaleSat(input logic signed [ACC_W-1:0] a,
                                               input logic [5:0] sh);
      logic signed [ACC_W-1:0] v;
      v = a >>> sh;
      if (v[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){v[ACC_W-1]}}) begin
         return {1'b0, v[OUT_W-1:0]};
      end else if (v[ACC_W-1]) begin
         return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      end
   endfunction

   // One extra bit so negating the most negative input cannot wrap.
   assign xRe     = {rx_src_real[IN_W-1], rx_src_real};
   assign xIm     = {rx_src_imag[IN_W-1], rx_src_imag};
   assign lenEff  = (cfg_int_len == '0) ? CNT_W'(1) : cfg_int_len;
   assign dumpNow = (stateQ == INTEG) && sopAl && (periodCnt == intLen);

   for (genvar k = 0; k < NUM_TAPS; k++) begin : gTap
      logic [OUT_W:0] resRe;
      logic [OUT_W:0] resIm;
      assign sExtRe[k] = {{(ACC_W-IN_W-1){sRe[k][IN_W]}}, sRe[k]};
      assign sExtIm[k] = {{(ACC_W-IN_W-1){sIm[k][IN_W]}}, sIm[k]};
      assign resRe = scaleSat(accRe[k], cfg_shift);
      assign resIm = scaleSat(accIm[k], cfg_shift);
      assign dumpReal[k*OUT_W +: OUT_W] = resRe[OUT_W-1:0];
      assign dumpImag[k*OUT_W +: OUT_W] = resIm[OUT_W-1:0];
      assign satVec[2*k]   = resRe[OUT_W];
      assign satVec[2*k+1] = resIm[OUT_W];
   end

   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         stateQ        <= WAIT_SOP;
         sopAl         <= 1'b0;
         periodCnt     <= '0;
         intLen        <= '0;
         tx_dump_valid <= 1'b0;
         tx_dump_real  <= '0;
         tx_dump_imag  <= '0;
         tx_dump_sat   <= 1'b0;
         tx_dump_ovf   <= 1'b0;
         tx_dump_cnt   <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            sRe[k]   <= '0;
            sIm[k]   <= '0;
            accRe[k] <= '0;
            accIm[k] <= '0;
         end
      end else begin
         sopAl <= rx_prn_sop;
         for (int k = 0; k < NUM_TAPS; k++) begin
            sRe[k] <= rx_loc_boc[k] ? -xRe : xRe;
            sIm[k] <= rx_loc_boc[k] ? -xIm : xIm;
         end

         case (stateQ)
            WAIT_SOP: begin
               if (sopAl) begin
                  stateQ    <= INTEG;
                  periodCnt <= CNT_W'(1);
                  intLen    <= lenEff;
                  for (int k = 0; k < NUM_TAPS; k++) begin
                     accRe[k] <= sExtRe[k];
                     accIm[k] <= sExtIm[k];
                  end
               end
            end
            default: begin
               if (dumpNow) begin
                  periodCnt <= CNT_W'(1);
                  intLen    <= lenEff;
                  for (int k = 0; k < NUM_TAPS; k++) begin
                     accRe[k] <= sExtRe[k];
                     accIm[k] <= sExtIm[k];
                  end
               end else begin
                  if (sopAl) begin
                     periodCnt <= periodCnt + CNT_W'(1);
                  end
                  for (int k = 0; k < NUM_TAPS; k++) begin
                     accRe[k] <= accRe[k] + sExtRe[k];
                     accIm[k] <= accIm[k] + sExtIm[k];
                  end
               end
            end
         endcase

         // A load in the acceptance cycle is not an overflow.
         if (dumpNow) begin
            tx_dump_real  <= dumpReal;
            tx_dump_imag  <= dumpImag;
            tx_dump_sat   <= |satVec;
            tx_dump_ovf   <= tx_dump_valid & ~tx_dump_ready;
            tx_dump_valid <= 1'b1;
            tx_dump_cnt   <= tx_dump_cnt + 16'd1;
         end else if (tx_dump_valid && tx_dump_ready) begin
            tx_dump_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_b1_trk_corr_bank.sv
// Randomised and directed bench for b1_trk_corr_bank against an integer-sum reference model.
module tb_b1_trk_corr_bank;

   localparam int NUM_TAPS = 3;
   localparam int IN_W     = 16;
   localparam int ACC_W    = 33;
   localparam int OUT_W    = 24;
   localparam int CNT_W    = 8;

   logic rx_clk = 1'b0;
   always #5 rx_clk = ~rx_clk;

   logic                      rx_rst;
   logic [IN_W-1:0]           rx_src_real;
   logic [IN_W-1:0]           rx_src_imag;
   logic [NUM_TAPS-1:0]       rx_loc_boc;
   logic                      rx_prn_sop;
   logic [CNT_W-1:0]          cfg_int_len;
   logic [5:0]                cfg_shift;
   logic                      tx_dump_valid;
   logic                      tx_dump_ready;
   logic [NUM_TAPS*OUT_W-1:0] tx_dump_real;
   logic [NUM_TAPS*OUT_W-1:0] tx_dump_imag;
   logic                      tx_dump_sat;
   logic                      tx_dump_ovf;
   logic [15:0]               tx_dump_cnt;

   b1_trk_corr_bank #(
      .NUM_TAPS(NUM_TAPS), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
   ) dut (
      .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_src_real(rx_src_real),
      .rx_src_imag(rx_src_imag), .rx_loc_boc(rx_loc_boc), .rx_prn_sop(rx_prn_sop),
      .cfg_int_len(cfg_int_len), .cfg_shift(cfg_shift), .tx_dump_valid(tx_dump_valid),
      .tx_dump_ready(tx_dump_ready), .tx_dump_real(tx_dump_real),
      .tx_dump_imag(tx_dump_imag), .tx_dump_sat(tx_dump_sat), .tx_dump_ovf(tx_dump_ovf),
      .tx_dump_cnt(tx_dump_cnt)
   );

   int nVec = 0;
   int nErr = 0;

   // Model: a period's samples are plain integer sums; events are seen one cycle late.
   bit     mInteg;
   int     mCnt, mLen;
   longint mSumRe [NUM_TAPS];
   longint mSumIm [NUM_TAPS];
   bit     alSop;
   longint alRe [NUM_TAPS];
   longint alIm [NUM_TAPS];
   bit     eValid, eSat, eOvf;
   int     eCnt;
   longint eRe [NUM_TAPS];
   longint eIm [NUM_TAPS];

   task automatic chk(input string nm, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   function automatic logic signed [63:0] tapRe(input int k);
      logic signed [OUT_W-1:0] t;
      t = tx_dump_real[k*OUT_W +: OUT_W];
      return t;
   endfunction

   function automatic logic signed [63:0] tapIm(input int k);
      logic signed [OUT_W-1:0] t;
      t = tx_dump_imag[k*OUT_W +: OUT_W];
      return t;
   endfunction

   function automatic longint satv(input longint s, input int sh, inout bit clip);
      longint v, mx, mn;
      v  = s >>> sh;
      mx = (longint'(1) <<< (OUT_W-1)) - 1;
      mn = -mx - 1;
      if (v > mx) begin clip = 1'b1; return mx; end
      if (v < mn) begin clip = 1'b1; return mn; end
      return v;
   endfunction

   task automatic modelStep();
      bit     load, clip;
      longint dRe [NUM_TAPS];
      longint dIm [NUM_TAPS];
      longint x, y;
      if (rx_rst) begin
         mInteg = 0; mCnt = 0; mLen = 0; alSop = 0;
         eValid = 0; eSat = 0; eOvf = 0; eCnt = 0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            mSumRe[k] = 0; mSumIm[k] = 0; alRe[k] = 0; alIm[k] = 0; eRe[k] = 0; eIm[k] = 0;
         end
         return;
      end
      load = 0;
      if (alSop && mInteg && mCnt == mLen) begin
         load = 1;
         dRe = mSumRe;
         dIm = mSumIm;
      end
      if (alSop && (!mInteg || load)) begin
         mInteg = 1; mCnt = 1;
         mLen = (cfg_int_len == 0) ? 1 : int'(cfg_int_len);
         mSumRe = alRe; mSumIm = alIm;
      end else if (mInteg) begin
         if (alSop) mCnt++;
         for (int k = 0; k < NUM_TAPS; k++) begin
            mSumRe[k] += alRe[k]; mSumIm[k] += alIm[k];
         end
      end
      if (load) begin
         clip = 0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            eRe[k] = satv(dRe[k], int'(cfg_shift), clip);
            eIm[k] = satv(dIm[k], int'(cfg_shift), clip);
         end
         eOvf = eValid && !tx_dump_ready;
         eSat = clip; eValid = 1; eCnt = (eCnt + 1) % 65536;
      end else if (eValid && tx_dump_ready) begin
         eValid = 0;
      end
      alSop = rx_prn_sop;
      x = longint'($signed(rx_src_real));
      y = longint'($signed(rx_src_imag));
      for (int k = 0; k < NUM_TAPS; k++) begin
         alRe[k] = rx_loc_boc[k] ? -x : x;
         alIm[k] = rx_loc_boc[k] ? -y : y;
      end
   endtask

   task automatic compare();
      chk("valid", tx_dump_valid, eValid);
      chk("dump_cnt", tx_dump_cnt, eCnt);
      if (eValid) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            chk($sformatf("real[%0d]", k), tapRe(k), eRe[k]);
            chk($sformatf("imag[%0d]", k), tapIm(k), eIm[k]);
         end
         chk("sat", tx_dump_sat, eSat);
         chk("ovf", tx_dump_ovf, eOvf);
      end
   endtask

   // Inputs are set after a negedge; sample outputs at the following negedge.
   task automatic tick();
      modelStep();
      @(posedge rx_clk);
      @(negedge rx_clk);
      compare();
   endtask

   task automatic doReset();
      rx_rst = 1; rx_prn_sop = 0;
      tick(); tick();
      rx_rst = 0;
   endtask

   initial begin
      rx_rst = 1; rx_src_real = 1; rx_src_imag = 16'hFFFE; rx_loc_boc = 0; rx_prn_sop = 0;
      cfg_int_len = 1; cfg_shift = 0; tx_dump_ready = 1;

      // T1: plain sums, 1-cycle-wide valid
      doReset();
      chk("T1 reset valid", tx_dump_valid, 0);
      chk("T1 reset cnt", tx_dump_cnt, 0);
      for (int n = 0; n < 18; n++) begin
         rx_prn_sop = (n % 8 == 0);
         tick();
         if (n == 8) chk("T1 valid before latency", tx_dump_valid, 0);
         if (n == 9) begin
            chk("T1 valid", tx_dump_valid, 1);
            for (int k = 0; k < NUM_TAPS; k++) begin
               chk("T1 real", tapRe(k), 8);
               chk("T1 imag", tapIm(k), -16);
            end
         end
         if (n == 10) chk("T1 valid drop", tx_dump_valid, 0);
      end

      // T2: tap 1 negated
      doReset();
      rx_loc_boc = 3'b010;
      for (int n = 0; n < 10; n++) begin
         rx_prn_sop = (n % 8 == 0);
         tick();
         if (n == 9) begin
            chk("T2 real1", tapRe(1), -8);
            chk("T2 imag1", tapIm(1), 16);
            chk("T2 real0", tapRe(0), 8);
            chk("T2 real2", tapRe(2), 8);
            chk("T2 sat", tx_dump_sat, 0);
         end
      end

      // T3: int_len 4, changed to 2 mid-integration
      doReset();
      rx_loc_boc = 0; cfg_int_len = 4;
      for (int n = 0; n < 84; n++) begin
         rx_prn_sop = (n % 8 == 0);
         if (n == 40) cfg_int_len = 2;
         tick();
         if (n == 33) chk("T3 first", tapRe(0), 32);
         if (n == 65) chk("T3 current", tapRe(0), 32);
         if (n == 81) chk("T3 next", tapRe(0), 16);
      end

      // T4: overwrite while not ready, then accept
      doReset();
      cfg_int_len = 1;
      for (int n = 0; n < 20; n++) begin
         rx_prn_sop    = (n % 8 == 0);
         rx_src_real   = (n >= 8) ? 16'd3 : 16'd1;
         tx_dump_ready = (n >= 18);
         tick();
         if (n == 9) begin
            chk("T4 first real", tapRe(0), 8);
            chk("T4 first ovf", tx_dump_ovf, 0);
         end
         if (n == 17) begin
            chk("T4 valid", tx_dump_valid, 1);
            chk("T4 real", tapRe(0), 24);
            chk("T4 ovf", tx_dump_ovf, 1);
            chk("T4 cnt", tx_dump_cnt, 2);
         end
         if (n == 18) chk("T4 accepted", tx_dump_valid, 0);
      end

      // T5: saturation, then the same stimulus shifted down by 2
      doReset();
      rx_src_real = 16'd32767; rx_src_imag = 0; tx_dump_ready = 1;
      for (int n = 0; n < 2050; n++) begin
         rx_prn_sop = (n % 1024 == 0);
         cfg_shift  = (n >= 1100) ? 6'd2 : 6'd0;
         tick();
         if (n == 1025) begin
            chk("T5 sat real", tapRe(0), 24'h7FFFFF);
            chk("T5 sat flag", tx_dump_sat, 1);
         end
         if (n == 2049) begin
            chk("T5 shift real", tapRe(0), 8388352);
            chk("T5 shift sat", tx_dump_sat, 0);
         end
      end

      // T6: reset mid-integration with a pending dump
      doReset();
      rx_src_real = 1; rx_src_imag = 16'hFFFE; cfg_shift = 0; tx_dump_ready = 0;
      for (int n = 0; n < 26; n++) begin
         rx_prn_sop = (n % 8 == 0);
         rx_rst     = (n == 12);
         tick();
         if (n == 11) chk("T6 pending", tx_dump_valid, 1);
         if (n == 12) begin
            chk("T6 valid", tx_dump_valid, 0);
            chk("T6 cnt", tx_dump_cnt, 0);
         end
         if (n == 17) chk("T6 no dump 1st sop", tx_dump_valid, 0);
         if (n == 25) begin
            chk("T6 dump 2nd sop", tx_dump_valid, 1);
            chk("T6 cnt after", tx_dump_cnt, 1);
         end
      end
      rx_rst = 0;

      // Random traffic: short then long periods, random backpressure and config
      doReset();
      for (int i = 0; i < 6000; i++) begin
         rx_src_real   = 16'($urandom);
         rx_src_imag   = 16'($urandom);
         rx_loc_boc    = 3'($urandom_range(0, 7));
         rx_prn_sop    = (i < 3000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 149) == 0);
         tx_dump_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 49) == 0) cfg_int_len = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) cfg_shift = 6'($urandom_range(0, 10));
         if ($urandom_range(0, 999) == 0) cfg_shift = 6'd40;
         rx_rst        = ($urandom_range(0, 1999) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
